// File: rtl/bin_to_bcd_sequencer.sv
// bin_to_bcd_sequencer: sequential double-dabble binary-to-BCD converter.
// It processes one input bit per clock. After IN_WIDTH shift cycles it spends
// one more cycle registering the result, so done rises IN_WIDTH+1 edges after
// the edge that accepts start.
// Optional build macro BCD_SATURATE_EN: an out-of-range result shows all 9s.
module bin_to_bcd_sequencer #(
    parameter int IN_WIDTH   = 16,
    parameter int NUM_DIGITS = 4
) (
    input  logic                      clock_100Mhz,
    input  logic                      reset,
    input  logic                      start,
    input  logic [IN_WIDTH-1:0]       bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic                      overflow
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [IN_WIDTH-1:0] shift_reg;
    logic [BCD_W-1:0]    scratch;
    logic                sticky;
    logic [CNT_W-1:0]    bit_cnt;

    logic [BCD_W-1:0]    scratch_adj;
    logic [BCD_W-1:0]    result_bcd;
    logic                accept;

    // Add-3 correction on each digit independently; no carry crosses digits.
    always_comb begin
        scratch_adj = scratch;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (scratch[4*k +: 4] >= 4'd5)
                scratch_adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
        end
    end

    // Select the value that bcd_out takes when a conversion completes.
    always_comb begin
`ifdef BCD_SATURATE_EN
        result_bcd = sticky ? {NUM_DIGITS{4'h9}} : scratch;
`else
        result_bcd = scratch;
`endif
    end

    // start is honoured only when no conversion is running.
    assign accept = start && (state != SHIFT);

    // Conversion FSM. All outputs are registered. bcd_out and overflow change
    // only on the edge that enters DONE.
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            scratch   <= '0;
            sticky    <= 1'b0;
            bit_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd_out   <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        shift_reg <= bin_in;
                        scratch   <= '0;
                        sticky    <= 1'b0;
                        bit_cnt   <= CNT_W'(IN_WIDTH);
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end else begin
                        state     <= IDLE;
                    end
                end
                SHIFT: begin
                    if (bit_cnt != '0) begin
                        // Any bit pushed out of the top digit means the value is >= 10**NUM_DIGITS.
                        {scratch, shift_reg} <= {scratch_adj[BCD_W-2:0], shift_reg, 1'b0};
                        sticky  <= sticky | scratch_adj[BCD_W-1];
                        bit_cnt <= bit_cnt - 1'b1;
                    end else begin
                        bcd_out  <= result_bcd;
                        overflow <= sticky;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_sequencer.sv
// Testbench for bin_to_bcd_sequencer. It uses table-driven vectors,
// hand-written corner sequences and random values. Expected results come from
// an arithmetic reference model (value mod 10**digits).
module tb_bin_to_bcd_sequencer;

    localparam int IN_WIDTH   = 16;
    localparam int NUM_DIGITS = 4;
    localparam int LATENCY    = IN_WIDTH + 1;

    logic        clock_100Mhz = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    logic [15:0] last_bcd;
    logic        last_ovf;

    bin_to_bcd_sequencer #(.IN_WIDTH(IN_WIDTH), .NUM_DIGITS(NUM_DIGITS)) dut (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .start        (start),
        .bin_in       (bin_in),
        .busy         (busy),
        .done         (done),
        .bcd_out      (bcd_out),
        .overflow     (overflow)
    );

    always #5 clock_100Mhz = ~clock_100Mhz;

    typedef struct {
        logic [15:0] bin;
        logic [15:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: decimal digits of value mod 10**NUM_DIGITS.
    function automatic logic [15:0] ref_bcd(input int unsigned v);
        int unsigned m;
        logic [15:0] r;
        r = '0;
        if (v >= 10000) begin
`ifdef BCD_SATURATE_EN
            return 16'h9999;
`endif
        end
        m = v % 10000;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            r[4*d +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // Called at a negedge. Presents start for exactly one rising edge.
    task automatic issue(input logic [15:0] v);
        start  = 1'b1;
        bin_in = v;
        @(posedge clock_100Mhz);
        @(negedge clock_100Mhz);
        start  = 1'b0;
        bin_in = 16'hDEAD;
    endtask

    // Called at the negedge after the accepting edge. Waits for done and checks
    // busy and output stability along the way. A stray start can be injected
    // at cycle inject_at.
    task automatic wait_done(input int inject_at, output int lat);
        lat = -1;
        for (int k = 0; k <= 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (k < LATENCY) begin
                chk("busy_mid", {31'b0, busy}, 32'd1);
                chk("bcd_hold", {16'b0, bcd_out}, {16'b0, last_bcd});
                chk("ovf_hold", {31'b0, overflow}, {31'b0, last_ovf});
            end
            if (k == inject_at) begin
                start  = 1'b1;
                bin_in = 16'd42;
            end
            @(posedge clock_100Mhz);
            @(negedge clock_100Mhz);
            start = 1'b0;
        end
        if (lat < 0) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: no done within 40 cycles, expected %0d", LATENCY);
        end
    endtask

    // Checks that done arrived on time and that the result matches the model.
    task automatic check_result(input string name, input int unsigned v, input int lat);
        logic [15:0] eb;
        logic        eo;
        eb = ref_bcd(v);
        eo = (v >= 10000);
        chk({name, "_lat"}, lat, LATENCY);
        chk({name, "_busy_done"}, {31'b0, busy}, 32'd0);
        chk({name, "_bcd"}, {16'b0, bcd_out}, {16'b0, eb});
        chk({name, "_ovf"}, {31'b0, overflow}, {31'b0, eo});
        last_bcd = eb;
        last_ovf = eo;
    endtask

    task automatic convert(input string name, input logic [15:0] v);
        int lat;
        issue(v);
        wait_done(-1, lat);
        check_result(name, v, lat);
    endtask

    initial begin
        vec_t vecs [8];
        int   lat;
        logic [15:0] r;

`ifdef BCD_SATURATE_EN
        vecs[3] = '{16'd65535, 16'h9999, 1'b1};
        vecs[4] = '{16'd10000, 16'h9999, 1'b1};
`else
        vecs[3] = '{16'd65535, 16'h5535, 1'b1};
        vecs[4] = '{16'd10000, 16'h0000, 1'b1};
`endif
        vecs[0] = '{16'd0,    16'h0000, 1'b0};
        vecs[1] = '{16'd1234, 16'h1234, 1'b0};
        vecs[2] = '{16'd9999, 16'h9999, 1'b0};
        vecs[5] = '{16'd9,    16'h0009, 1'b0};
        vecs[6] = '{16'd10,   16'h0010, 1'b0};
        vecs[7] = '{16'd5005, 16'h5005, 1'b0};

        reset  = 1'b1;
        start  = 1'b0;
        bin_in = 16'd0;
        last_bcd = 16'h0;
        last_ovf = 1'b0;
        repeat (3) @(posedge clock_100Mhz);
        @(negedge clock_100Mhz);
        reset = 1'b0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_bcd",  {16'b0, bcd_out}, 32'h0);
        chk("rst_ovf",  {31'b0, overflow}, 32'd0);
        @(negedge clock_100Mhz);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].bin);
            wait_done(-1, lat);
            chk("tbl_lat", lat, LATENCY);
            chk("tbl_bcd", {16'b0, bcd_out}, {16'b0, vecs[i].exp_bcd});
            chk("tbl_ovf", {31'b0, overflow}, {31'b0, vecs[i].exp_ovf});
            last_bcd = vecs[i].exp_bcd;
            last_ovf = vecs[i].exp_ovf;
            @(negedge clock_100Mhz);
            chk("tbl_done_pulse", {31'b0, done}, 32'd0);
            chk("tbl_bcd_hold", {16'b0, bcd_out}, {16'b0, vecs[i].exp_bcd});
        end

        // Back-to-back: the second start is given in the DONE cycle of the first.
        convert("b2b_first", 16'd1234);
        issue(16'd9999);
        wait_done(-1, lat);
        check_result("b2b_second", 9999, lat);
        @(negedge clock_100Mhz);

        // A start 5 cycles into busy must be ignored.
        issue(16'd777);
        wait_done(5, lat);
        check_result("ignore", 777, lat);
        repeat (3) @(negedge clock_100Mhz);
        chk("ignore_no_extra", {30'b0, busy, done}, 32'd0);

        // Reset in the middle of a conversion.
        issue(16'd555);
        repeat (8) @(negedge clock_100Mhz);
        reset = 1'b1;
        @(negedge clock_100Mhz);
        reset = 1'b0;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_bcd", {16'b0, bcd_out}, 32'h0);
        chk("midrst_ovf", {31'b0, overflow}, 32'd0);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 25; k++) begin
                if (done) seen++;
                @(negedge clock_100Mhz);
            end
            chk("midrst_no_done", seen, 0);
        end
        last_bcd = 16'h0;
        last_ovf = 1'b0;
        convert("after_rst", 16'd4321);
        @(negedge clock_100Mhz);

        // Random values, some back-to-back.
        for (int i = 0; i < 30; i++) begin
            r = 16'($urandom_range(0, 65535));
            if (i % 3 == 0) r = 16'($urandom_range(0, 12000));
            issue(r);
            wait_done(-1, lat);
            check_result("rand", r, lat);
            if ($urandom_range(0, 1) == 1) @(negedge clock_100Mhz);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
